regfile_32x64: RTL
==================

# regfile_32x64

Thirty-two-entry, 64-bit register file with two asynchronous read ports and one synchronous write port. Sits directly downstream of the 5-to-32 write-address decoder: the decoder's one-hot output, gated by `RegWrite`, selects which register captures `WriteData` at the clock edge. Register 31 is the architectural zero register (XZR): it always reads as zero and ignores writes. Read data feeds the datapath ALU operand muxes.

## Interface
Parameters:
- `DATA_WIDTH`, 64: width of each register and of the read/write data buses.
- `ZERO_REG`, 31: index hardwired to zero; writes to it are discarded.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; clears every register on the rising edge of `clk` while high.
- `RegWrite` input 1: write enable for the current cycle.
- `WriteRegister` input 5: destination register index; fed to the 5-to-32 decoder.
- `WriteData` input DATA_WIDTH: value written to `WriteRegister`.
- `ReadRegister1` input 5: index for read port 1.
- `ReadRegister2` input 5: index for read port 2.
- `ReadData1` output DATA_WIDTH: contents of `ReadRegister1`.
- `ReadData2` output DATA_WIDTH: contents of `ReadRegister2`.

## Operation
- Storage: 31 writable registers (indices 0–30), each a bank of `DATA_WIDTH` D flip-flops; index 31 has no storage and reads as all zeros.
- Write decode: `WriteRegister` goes through the 5-to-32 decoder. Each one-hot bit is ANDed with `RegWrite` to form a per-register enable. An enabled register loads `WriteData`; every other register holds its value through a 2:1 hold mux on its D input. There is no clock gating.
- At most one register is enabled in a cycle. `RegWrite` = 0 means no register changes.
- A write to index 31 is a no-op: no storage changes and reads of 31 stay zero.
- Read ports: each is an independent 32:1 `DATA_WIDTH`-bit mux indexed by `ReadRegister1`/`ReadRegister2`, purely combinational from register state.
- Both ports may address the same register, including the one being written, with no conflict.
- Reset: when `reset` = 1 at a rising edge, every register becomes 0 regardless of `RegWrite`. Reset has priority over a simultaneous write.
- Out-of-range indices cannot occur, because the 5-bit index covers exactly 0–31.

## Timing
- Write latency: data presented in cycle N with `RegWrite` = 1 is stored at the rising edge ending cycle N. It appears on a read port addressing that register in cycle N+1. Bypass behaviour is described under Configuration.
- Read latency: combinational, no cycle of delay. `ReadDataX` settles within the same cycle after an index change or after a register update at the edge.
- Reset values: all registers are 0, so `ReadData1` = `ReadData2` = 0 in the cycle after reset is sampled, for every index.
- Reset asserted mid-sequence discards a write presented in the same cycle. Writes resume in the first cycle with `reset` = 0.
- Back-to-back writes to the same register every cycle are legal. The last value written wins.

## Configuration
- `REGFILE_BYPASS_EN`:
  - Defined: write-to-read forwarding is enabled. When `RegWrite` = 1, `WriteRegister` ≠ 31, and `ReadRegisterX` == `WriteRegister` in the same cycle, `ReadDataX` shows `WriteData` combinationally that cycle, before the edge. This holds for each port independently.
  - Defined, during reset: forwarding is suppressed while `reset` = 1.
  - Not defined: reads always return stored state, so a same-cycle read of the register being written returns the old value.

## Test plan
- Reset all: hold `reset` = 1 for one edge, then sweep both read indices 0–31. Required: all reads = 0.
- Basic write/read: write X5 = 0x0123_4567_89AB_CDEF with `RegWrite` = 1. Next cycle, read X5 on port 1 and X4 on port 2. Required: 0x0123_4567_89AB_CDEF and 0.
- Zero register: write X31 = 0xFFFF_FFFF_FFFF_FFFF. Next cycle, read X31 on both ports. Required: 0 on both; all other registers unchanged.
- Write disabled: `RegWrite` = 0, `WriteRegister` = 7, `WriteData` = 0xAA. Required: X7 keeps its prior value (0 after reset).
- Same-cycle read of the written register: X9 holds 0x11. Write X9 = 0x22 while reading X9 on both ports. Required before the edge: 0x11 without the macro, 0x22 with it. After the edge: 0x22 in both builds.
- Reset vs write: X3 holds 0x55. In one cycle assert `reset` = 1, `RegWrite` = 1, `WriteRegister` = 3, `WriteData` = 0x99. Required: X3 = 0 the next cycle.

Source files
------------

// File: rtl/regfile_32x64.sv
// 32 x DATA_WIDTH register file: two combinational read ports, one write port.
// Entry ZERO_REG reads as zero. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_32x64 #(
  parameter int DATA_WIDTH = 64,
  parameter int ZERO_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [4:0]            WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [4:0]            ReadRegister1,
  input  logic [4:0]            ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  localparam logic [4:0] ZR = ZERO_REG[4:0];

  logic [DATA_WIDTH-1:0] regs_q [32];
  logic [DATA_WIDTH-1:0] regs_d [32];
  logic [DATA_WIDTH-1:0] rd_vec [32];
  logic [31:0]           dec;
  logic [31:0]           we;

  function automatic logic [31:0] dec5(input logic [4:0] a);
    dec5 = 32'd1 << a;
  endfunction

  always_comb begin
    dec = dec5(WriteRegister);
    we  = dec & {32{RegWrite}};
    we[ZR] = 1'b0;
  end

  // Hold mux on every D input; the zero entry is tied off and folds away
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = we[i] ? WriteData : regs_q[i];
    end
    regs_d[ZR] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      rd_vec[i] = regs_q[i];
    end
    rd_vec[ZR] = '0;
  end

`ifdef REGFILE_BYPASS_EN
  logic byp_ok;
  logic byp1;
  logic byp2;

  always_comb begin
    byp_ok = !reset && RegWrite && (WriteRegister != ZR);
    byp1   = byp_ok && (ReadRegister1 == WriteRegister);
    byp2   = byp_ok && (ReadRegister2 == WriteRegister);
  end

  assign ReadData1 = byp1 ? WriteData : rd_vec[ReadRegister1];
  assign ReadData2 = byp2 ? WriteData : rd_vec[ReadRegister2];
`else
  assign ReadData1 = rd_vec[ReadRegister1];
  assign ReadData2 = rd_vec[ReadRegister2];
`endif

endmodule
